// File: rtl/vmem_pkg.sv
// Shared sizing, request record and FSM encoding for the vector memory issue queue.
package vmem_pkg;

  localparam int ADDR_RANGE          = 32768;
  localparam int AW                  = $clog2(ADDR_RANGE) + 2;
  localparam int LANES_DATA_WIDTH    = 64;
  localparam int NUMBER_VECTOR_LANES = 4;
  localparam int NL                  = NUMBER_VECTOR_LANES;
  localparam int ID_W                = 5;

  localparam logic [1:0] MODE_UNIT    = 2'd0;
  localparam logic [1:0] MODE_STRIDED = 2'd1;
  localparam logic [1:0] MODE_INDEXED = 2'd2;

  typedef logic [NL-1:0][LANES_DATA_WIDTH-1:0] lanes_t;

  typedef struct packed {
    logic [ID_W-1:0] dest_id;
    logic            is_load;
    logic [1:0]      mode;
    logic [2:0]      sew;
    logic [2:0]      indexed_sew;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   stride;
    lanes_t          wrdata;
    lanes_t          indexed;
  } vmem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETIRE
  } vmem_state_e;

endpackage

// File: rtl/vmem_req_fifo.sv
// Synchronous FIFO of vmem_req_t; exposes the head and the entry behind it so a
// retire can hand the following request straight to the issue register.
module vmem_req_fifo
  import vmem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  vmem_req_t     push_data,
  input  logic          pop,
  output vmem_req_t     head,
  output vmem_req_t     next_head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  vmem_req_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + PW'(1)];

  // NOTE: the entry array is deliberately not reset; count gates every read,
  // so clearing hundreds of data bits would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/vmem_issue_queue.sv
// Buffers vector load/store requests and issues them one at a time to top_mem,
// holding each one stable until its completion is seen, then retiring it.
module vmem_issue_queue
  import vmem_pkg::*;
#(
  parameter  int QUEUE_DEPTH = 4,
  localparam int CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [ID_W-1:0] destination_id_in,
  input  logic            load_in,
  input  logic            store_in,
  input  logic [1:0]      mode_in,
  input  logic [2:0]      sew_in,
  input  logic [2:0]      indexed_sew_in,
  input  logic [AW-1:0]   addr_in,
  input  logic [AW-1:0]   stride_in,
  input  lanes_t          wrdata_in,
  input  lanes_t          indexed_in,
  output logic            enable_out,
  output logic [ID_W-1:0] destination_id_out,
  output logic            load_operation,
  output logic            store_operation,
  output logic [1:0]      mode_out,
  output logic [2:0]      sew_out,
  output logic [2:0]      indexed_sew_out,
  output logic [AW-1:0]   addr_out,
  output logic [AW-1:0]   stride_out,
  output lanes_t          wrdata_out,
  output lanes_t          indexed_out,
  input  logic [NL-1:0]   valid_read,
  input  logic            store_done,
  output logic            done_valid,
  output logic [ID_W-1:0] done_id,
  output logic            done_is_load,
  output logic [CW-1:0]   count,
  output logic            busy
);

  vmem_state_e   state;
  vmem_req_t     in_req;
  vmem_req_t     head;
  vmem_req_t     next_head;
  vmem_req_t     cur;
  vmem_req_t     issue_src;
  logic          full;
  logic          empty;
  logic          pop;
  logic          retire_now;
  logic          issue_now;
  logic [NL-1:0] lane_mask;
  logic [NL-1:0] lane_seen;
  logic          unused_store_in;

  // The operation type is carried by load_in alone; store_in is its complement.
  assign unused_store_in = store_in;

  assign in_req = '{
    dest_id:     destination_id_in,
    is_load:     load_in,
    mode:        mode_in,
    sew:         sew_in,
    indexed_sew: indexed_sew_in,
    addr:        addr_in,
    stride:      stride_in,
    wrdata:      wrdata_in,
    indexed:     indexed_in
  };

  assign ready_out = !full;
  assign busy      = (state != IDLE);
  assign pop       = (state == RETIRE);
  assign lane_seen = lane_mask | valid_read;

  vmem_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (valid_in && ready_out),
    .push_data (in_req),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Leaving RETIRE the head is being popped on the same edge, so the request
  // behind it is taken; a push landing on that edge is issued via IDLE instead.
  assign retire_now = (state == WAIT) && (cur.is_load ? (&lane_seen) : store_done);
  assign issue_now  = ((state == IDLE) && !empty) ||
                      ((state == RETIRE) && (count > CW'(1)));
  assign issue_src  = (state == RETIRE) ? next_head : head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cur             <= '0;
      lane_mask       <= '0;
      enable_out      <= 1'b0;
      load_operation  <= 1'b0;
      store_operation <= 1'b0;
      done_valid      <= 1'b0;
      done_id         <= '0;
      done_is_load    <= 1'b0;
    end else begin
      enable_out <= 1'b0;
      done_valid <= 1'b0;

      if (issue_now) begin
        cur             <= issue_src;
        load_operation  <= issue_src.is_load;
        store_operation <= !issue_src.is_load;
        enable_out      <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (issue_now) state <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cur.is_load) lane_mask <= lane_seen;
          if (retire_now) begin
            state        <= RETIRE;
            done_valid   <= 1'b1;
            done_id      <= cur.dest_id;
            done_is_load <= cur.is_load;
          end
        end
        RETIRE: begin
          lane_mask <= '0;
          state     <= issue_now ? ISSUE : IDLE;
        end
      endcase
    end
  end

  // Head fields come straight from the issue register so they hold from ISSUE
  // through RETIRE while top_mem samples them after its control delay.
  assign destination_id_out = cur.dest_id;
  assign mode_out           = cur.mode;
  assign sew_out            = cur.sew;
  assign indexed_sew_out    = cur.indexed_sew;
  assign addr_out           = cur.addr;
  assign stride_out         = cur.stride;
  assign wrdata_out         = cur.wrdata;
  assign indexed_out        = cur.indexed;

endmodule

// File: tb/tb_vmem_issue_queue.sv
// Randomised bench for vmem_issue_queue against a transaction-level queue model.
module tb_vmem_issue_queue;
  import vmem_pkg::*;

  localparam int QD = 4;
  localparam int CW = $clog2(QD) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in;
  logic            ready_out;
  logic [ID_W-1:0] destination_id_in;
  logic            load_in;
  logic            store_in;
  logic [1:0]      mode_in;
  logic [2:0]      sew_in;
  logic [2:0]      indexed_sew_in;
  logic [AW-1:0]   addr_in;
  logic [AW-1:0]   stride_in;
  lanes_t          wrdata_in;
  lanes_t          indexed_in;
  logic            enable_out;
  logic [ID_W-1:0] destination_id_out;
  logic            load_operation;
  logic            store_operation;
  logic [1:0]      mode_out;
  logic [2:0]      sew_out;
  logic [2:0]      indexed_sew_out;
  logic [AW-1:0]   addr_out;
  logic [AW-1:0]   stride_out;
  lanes_t          wrdata_out;
  lanes_t          indexed_out;
  logic [NL-1:0]   valid_read;
  logic            store_done;
  logic            done_valid;
  logic [ID_W-1:0] done_id;
  logic            done_is_load;
  logic [CW-1:0]   count;
  logic            busy;

  always #5 clk = ~clk;

  vmem_issue_queue #(.QUEUE_DEPTH(QD)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .ready_out          (ready_out),
    .destination_id_in  (destination_id_in),
    .load_in            (load_in),
    .store_in           (store_in),
    .mode_in            (mode_in),
    .sew_in             (sew_in),
    .indexed_sew_in     (indexed_sew_in),
    .addr_in            (addr_in),
    .stride_in          (stride_in),
    .wrdata_in          (wrdata_in),
    .indexed_in         (indexed_in),
    .enable_out         (enable_out),
    .destination_id_out (destination_id_out),
    .load_operation     (load_operation),
    .store_operation    (store_operation),
    .mode_out           (mode_out),
    .sew_out            (sew_out),
    .indexed_sew_out    (indexed_sew_out),
    .addr_out           (addr_out),
    .stride_out         (stride_out),
    .wrdata_out         (wrdata_out),
    .indexed_out        (indexed_out),
    .valid_read         (valid_read),
    .store_done         (store_done),
    .done_valid         (done_valid),
    .done_id            (done_id),
    .done_is_load       (done_is_load),
    .count              (count),
    .busy               (busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: accepted requests in order; the in-flight one is mq[0].
  vmem_req_t     mq[$];
  vmem_req_t     cur_req;
  bit            pop_next;
  bit            exp_done;
  bit            inflight;
  bit            in_wait;
  logic [NL-1:0] mask;
  int            stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_req();
    destination_id_in = ID_W'($urandom_range(0, 31));
    load_in           = 1'($urandom_range(0, 1));
    store_in          = !load_in;
    mode_in           = 2'($urandom_range(0, 2));
    sew_in            = 3'($urandom);
    indexed_sew_in    = 3'($urandom);
    addr_in           = AW'($urandom);
    stride_in         = AW'($urandom);
    for (int l = 0; l < NL; l++) begin
      wrdata_in[l]  = {$urandom, $urandom};
      indexed_in[l] = {$urandom, $urandom};
    end
  endtask

  // One clock: apply the model's view of the edge, then compare outputs.
  task automatic step();
    bit        acc;
    vmem_req_t pend;
    vmem_req_t obs;
    vmem_req_t tmp;
    acc  = valid_in && rst && (mq.size() < QD);
    pend = '{dest_id: destination_id_in, is_load: load_in, mode: mode_in, sew: sew_in,
             indexed_sew: indexed_sew_in, addr: addr_in, stride: stride_in,
             wrdata: wrdata_in, indexed: indexed_in};
    @(posedge clk);
    #1;
    if (!rst) begin
      mq.delete();
      exp_done = 0; inflight = 0; in_wait = 0; mask = '0;
    end else begin
      if (pop_next) tmp = mq.pop_front();
      if (acc) mq.push_back(pend);
    end
    pop_next = 0;
    obs = '{dest_id: destination_id_out, is_load: load_operation, mode: mode_out, sew: sew_out,
            indexed_sew: indexed_sew_out, addr: addr_out, stride: stride_out,
            wrdata: wrdata_out, indexed: indexed_out};

    check("count", 64'(count), 64'(mq.size()));
    check("ready_out", 64'(ready_out), 64'(mq.size() < QD));
    if (inflight && !enable_out) check("hold_fields", 64'(obs == cur_req), 64'(1));
    check("done_valid", 64'(done_valid), 64'(exp_done));
    if (exp_done && mq.size() > 0) begin
      check("done_id", 64'(done_id), 64'(mq[0].dest_id));
      check("done_is_load", 64'(done_is_load), 64'(mq[0].is_load));
      pop_next = 1;
      inflight = 0;
      in_wait  = 0;
    end
    exp_done = 0;
    if (inflight) in_wait = 1;
    if (enable_out) begin
      check("issue_nonempty", 64'(mq.size() != 0), 64'(1));
      if (mq.size() > 0) begin
        check("issue_dest", 64'(destination_id_out), 64'(mq[0].dest_id));
        check("issue_store_op", 64'(store_operation), 64'(!mq[0].is_load));
        check("issue_fields", 64'(obs == mq[0]), 64'(1));
        cur_req = mq[0];
      end
      inflight = 1; in_wait = 0; mask = '0;
    end
    if (mq.size() > 0 && !inflight && !pop_next) stall++; else stall = 0;
    if (stall > 3) begin
      check("issue_stall", 64'(stall), 64'(3));
      stall = 0;
    end
  endtask

  // Random completion traffic; strays land outside WAIT or on the wrong type.
  task automatic drive_resp();
    logic [NL-1:0] vr;
    logic          sd;
    vr = NL'($urandom);
    sd = 1'($urandom_range(0, 1));
    valid_read = '0;
    store_done = 1'b0;
    if (in_wait) begin
      if ($urandom_range(0, 2) != 0) begin
        valid_read = vr;
        store_done = sd;
        if (cur_req.is_load) begin
          if (&(mask | vr)) exp_done = 1;
          mask = mask | vr;
        end else if (sd) begin
          exp_done = 1;
        end
      end
    end else if ($urandom_range(0, 3) == 0) begin
      valid_read = vr;
      store_done = sd;
    end
  endtask

  // Steps to the head's WAIT state, completes it, and returns at the retire pulse.
  task automatic complete_head();
    int n = 0;
    while (!in_wait && n < 20) begin
      step();
      n++;
    end
    check("reach_wait", 64'(in_wait), 64'(1));
    if (in_wait) begin
      if (cur_req.is_load) valid_read = '1;
      else store_done = 1'b1;
      exp_done = 1;
      step();
      valid_read = '0;
      store_done = 1'b0;
    end
  endtask

  initial begin
    lanes_t wr_exp;
    bit     seen_done;
    int     n;

    rst = 1'b0; valid_in = 1'b0; valid_read = '0; store_done = 1'b0;
    rand_req();
    step();
    step();
    check("rst_enable", 64'(enable_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done_valid), 64'(0));
    check("rst_load_op", 64'(load_operation), 64'(0));
    check("rst_store_op", 64'(store_operation), 64'(0));
    check("rst_addr", 64'(addr_out), 64'(0));
    check("rst_wrdata_zero", 64'(wrdata_out == '0), 64'(1));
    rst = 1'b1;
    step();

    // Single unit-stride load, completion split over two lane groups.
    rand_req();
    destination_id_in = 5'd5; load_in = 1'b1; store_in = 1'b0;
    mode_in = MODE_UNIT; addr_in = AW'(32'h100);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("no_bypass", 64'(enable_out), 64'(0));
    step();
    check("lat_enable", 64'(enable_out), 64'(1));
    check("load_addr", 64'(addr_out), 64'(32'h100));
    step();
    check("enable_pulse", 64'(enable_out), 64'(0));
    valid_read = 4'b0011; mask = mask | valid_read;
    step();
    check("partial_lanes", 64'(done_valid), 64'(0));
    valid_read = 4'b1100; mask = mask | valid_read; exp_done = 1;
    step();
    valid_read = '0;
    check("load_done_id", 64'(done_id), 64'(5));
    check("load_done_is_load", 64'(done_is_load), 64'(1));
    step();
    check("load_drained", 64'(count), 64'(0));

    // Single store: write data held through stray valid_read until store_done.
    rand_req();
    load_in = 1'b0; store_in = 1'b1; wr_exp = wrdata_in;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    repeat (3) begin
      valid_read = '1;
      step();
    end
    valid_read = '0;
    check("store_stray_busy", 64'(busy), 64'(1));
    store_done = 1'b1; exp_done = 1;
    step();
    store_done = 1'b0;
    check("store_done_is_load", 64'(done_is_load), 64'(0));
    for (int l = 0; l < NL; l++) check("store_wrdata_lane", wrdata_out[l], wr_exp[l]);
    step();

    // Load with stray store_done.
    rand_req();
    load_in = 1'b1; store_in = 1'b0;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    repeat (3) begin
      store_done = 1'b1;
      step();
    end
    store_done = 1'b0;
    check("load_stray_busy", 64'(busy), 64'(1));
    complete_head();
    check("load_stray_done", 64'(done_is_load), 64'(1));
    step();

    // Fill beyond depth, push during RETIRE when full, drain in FIFO order.
    for (int i = 0; i < 5; i++) begin
      rand_req();
      destination_id_in = ID_W'(10 + i);
      valid_in = 1'b1;
      step();
      if (i == 3) check("fill_ready", 64'(ready_out), 64'(0));
    end
    valid_in = 1'b0;
    check("fill_count", 64'(count), 64'(4));
    complete_head();
    check("fill_order0", 64'(done_id), 64'(10));
    rand_req();
    destination_id_in = 5'd31;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("retire_push_refused", 64'(count), 64'(3));
    for (int i = 1; i < 4; i++) begin
      complete_head();
      check("fill_order", 64'(done_id), 64'(10 + i));
    end
    step();
    check("fill_drained", 64'(count), 64'(0));

    // Reset during WAIT abandons the request without a retire pulse.
    rand_req();
    load_in = 1'b1; store_in = 1'b0;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    valid_read = 4'b0001; mask = mask | valid_read;
    step();
    valid_read = '0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_count", 64'(count), 64'(0));
    check("midrst_enable", 64'(enable_out), 64'(0));
    check("midrst_ready", 64'(ready_out), 64'(1));
    seen_done = 0;
    repeat (8) begin
      valid_read = '1; store_done = 1'b1;
      step();
      if (done_valid) seen_done = 1;
    end
    valid_read = '0; store_done = 1'b0;
    check("midrst_no_done", 64'(seen_done), 64'(0));

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      rand_req();
      valid_in = ($urandom_range(0, 2) == 0);
      drive_resp();
      step();
    end
    valid_in = 1'b0;
    n = 0;
    while ((mq.size() != 0 || pop_next) && n < 300) begin
      drive_resp();
      step();
      n++;
    end
    valid_read = '0; store_done = 1'b0;
    check("random_drained", 64'(mq.size()), 64'(0));
    step();
    check("final_busy", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
